spi_flash_loader: RTL

- SPI mode-0 slave that receives the boot-programming stream from the external SPI master.
- The stream is an address opcode followed by 4 bytes, and a data opcode followed by 4 bytes, all MSB-first.
- Each completed data word becomes a single-word memory write request into the core's imem/dmem/SRAM fabric.
- Sits at the chip's SPI pins, inside the SPIRSTN domain, ahead of the memory write mux.

---
 rtl/spi_loader_pkg.sv | 16 +
 rtl/spi_flash_loader_if.sv | 20 ++
 rtl/spi_slave_shifter.sv | 101 ++++++++++
 rtl/spi_flash_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI flash loader: command opcodes and the
// parser state encoding used by the top-level FSM.
package spi_loader_pkg;

    localparam logic [7:0] OP_ADDR = 8'h01;
    localparam logic [7:0] OP_DATA = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        READ = 2'd3
    } state_e;

endpackage

// File: rtl/spi_flash_loader_if.sv
// Memory write port of the SPI flash loader.
// Optional macro SPI_FLASH_LOADER_READBACK_EN adds the read strobe and read data.
interface spi_flash_loader_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
`ifdef SPI_FLASH_LOADER_READBACK_EN
    logic        re;
    logic [31:0] rdata;

    modport master (output req, addr, wdata, re, input gnt, rdata);
    modport slave  (input req, addr, wdata, re, output gnt, rdata);
`else
    modport master (output req, addr, wdata, input gnt);
    modport slave  (input req, addr, wdata, output gnt);
`endif

endinterface

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave bit engine: pin synchronizers, SCLK edge detection,
// MSB-first byte assembly with a one-cycle byte strobe, and the MISO
// shifter. MISO changes on detected SCLK falls so the master samples a
// stable bit on its next rising edge.
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    input  logic       load_en,
    input  logic [7:0] load_byte,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       miso_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   byte_valid_r;
    logic [7:0]             byte_data_r;
    logic [7:0]             miso_shift_r;
    logic                   miso_r;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       rise_s;
    logic       fall_s;
    logic [7:0] miso_src_s;

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s = sclk_s & ~sclk_prev_r;
    assign fall_s = ~sclk_s & sclk_prev_r;
    // A load landing on the same cycle as a fall must still shift out its MSB.
    assign miso_src_s = load_en ? load_byte : miso_shift_r;

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;
    assign miso_o     = miso_r;

    // Bring the asynchronous SPI pins into the clk_i domain and keep the previous SCLK.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '1;
            mosi_sync_r <= '0;
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_ni};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_r <= sclk_s;
        end
    end

    // Assemble MOSI bytes; CS high discards any partial byte.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
        end else if (cs_s) begin
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
        end else if (rise_s) begin
            shift_r      <= {shift_r[6:0], mosi_s};
            bit_cnt_r    <= bit_cnt_r + 3'd1;
            byte_valid_r <= (bit_cnt_r == 3'd7);
            if (bit_cnt_r == 3'd7) begin
                byte_data_r <= {shift_r[6:0], mosi_s};
            end
        end else begin
            byte_valid_r <= 1'b0;
        end
    end

    // MISO shifter: loaded on request, advanced on each SCLK fall inside a frame.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            miso_shift_r <= 8'h00;
            miso_r       <= 1'b0;
        end else if (fall_s && !cs_s) begin
            miso_r       <= miso_src_s[7];
            miso_shift_r <= {miso_src_s[6:0], 1'b0};
        end else if (load_en) begin
            miso_shift_r <= load_byte;
        end
    end

endmodule

// File: rtl/spi_flash_loader.sv
// SPI boot loader: parses ADDR/DATA command streams from the SPI slave
// engine and turns each completed data word into a single memory write.
// Optional macro SPI_FLASH_LOADER_READBACK_EN enables the 0x03 read command.
module spi_flash_loader
    import spi_loader_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ADDR_INC    = 32'd4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sclk_i,
    input  logic               cs_ni,
    input  logic               mosi_i,
    output logic               miso_o,
    output logic               busy_o,
    output logic               overrun_o,
    spi_flash_loader_if.master mem
);

    state_e      state_r,   state_n;
    logic [1:0]  cnt_r,     cnt_n;
    logic [31:0] addr_sh_r, addr_sh_n;
    logic [31:0] data_sh_r, data_sh_n;
    logic [31:0] addr_r,    addr_n;
    logic [31:0] wdata_r,   wdata_n;
    logic        req_r,     req_n;
    logic        overrun_r, overrun_n;
    logic        busy_r,    busy_n;
`ifdef SPI_FLASH_LOADER_READBACK_EN
    logic        re_r,      re_n;
    logic [23:0] rd_word_r, rd_word_n;
`endif

    logic       byte_valid_s;
    logic [7:0] byte_data_s;
    logic       load_en_s;
    logic [7:0] load_byte_s;

    spi_slave_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sclk_i     (sclk_i),
        .cs_ni      (cs_ni),
        .mosi_i     (mosi_i),
        .load_en    (load_en_s),
        .load_byte  (load_byte_s),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .miso_o     (miso_o)
    );

    assign mem.req    = req_r;
    assign mem.addr   = addr_r;
    assign mem.wdata  = wdata_r;
    assign busy_o     = busy_r;
    assign overrun_o  = overrun_r;
`ifdef SPI_FLASH_LOADER_READBACK_EN
    assign mem.re     = re_r;
`endif

    // Parser next state, write handshake and MISO load selection.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        addr_sh_n   = addr_sh_r;
        data_sh_n   = data_sh_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        req_n       = req_r;
        overrun_n   = overrun_r;
        load_en_s   = byte_valid_s;
        load_byte_s = byte_data_s;
`ifdef SPI_FLASH_LOADER_READBACK_EN
        re_n        = re_r;
        rd_word_n   = rd_word_r;
`endif

        // Grant completes the request; a read hands its MSB straight to MISO.
        if (req_r && mem.gnt) begin
            req_n = 1'b0;
`ifdef SPI_FLASH_LOADER_READBACK_EN
            if (re_r) begin
                re_n        = 1'b0;
                rd_word_n   = mem.rdata[23:0];
                load_en_s   = 1'b1;
                load_byte_s = mem.rdata[31:24];
            end else begin
                addr_n = addr_r + ADDR_INC;
            end
`else
            addr_n = addr_r + ADDR_INC;
`endif
        end else begin
            req_n = req_r;
        end

        // Byte strobe advances the parser; ADDR completion overrides the increment.
        if (byte_valid_s) begin
            case (state_r)
                IDLE: begin
                    cnt_n = 2'd0;
                    if (byte_data_s == OP_ADDR) begin
                        state_n = ADDR;
                    end else if (byte_data_s == OP_DATA) begin
                        state_n = DATA;
`ifdef SPI_FLASH_LOADER_READBACK_EN
                    end else if (byte_data_s == OP_READ && !req_r) begin
                        state_n = READ;
                        req_n   = 1'b1;
                        re_n    = 1'b1;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
                ADDR: begin
                    addr_sh_n = {addr_sh_r[23:0], byte_data_s};
                    cnt_n     = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        addr_n  = addr_sh_n;
                        state_n = IDLE;
                    end else begin
                        state_n = ADDR;
                    end
                end
                DATA: begin
                    data_sh_n = {data_sh_r[23:0], byte_data_s};
                    cnt_n     = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        if (!req_r) begin
                            wdata_n = data_sh_n;
                            req_n   = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
`ifdef SPI_FLASH_LOADER_READBACK_EN
                READ: begin
                    cnt_n     = cnt_r + 2'd1;
                    load_en_s = 1'b1;
                    case (cnt_r)
                        2'd0:    load_byte_s = rd_word_r[23:16];
                        2'd1:    load_byte_s = rd_word_r[15:8];
                        2'd2:    load_byte_s = rd_word_r[7:0];
                        default: load_byte_s = byte_data_s;
                    endcase
                    if (cnt_r == 2'd3) begin
                        addr_n  = addr_r + ADDR_INC;
                        state_n = IDLE;
                    end else begin
                        state_n = READ;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end

        busy_n = (state_n != IDLE) || req_n;
    end

    // Parser and handshake registers; reset drops any frame or pending request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            addr_sh_r <= 32'h0000_0000;
            data_sh_r <= 32'h0000_0000;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            req_r     <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SPI_FLASH_LOADER_READBACK_EN
            re_r      <= 1'b0;
            rd_word_r <= 24'h00_0000;
`endif
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            addr_sh_r <= addr_sh_n;
            data_sh_r <= data_sh_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            req_r     <= req_n;
            overrun_r <= overrun_n;
            busy_r    <= busy_n;
`ifdef SPI_FLASH_LOADER_READBACK_EN
            re_r      <= re_n;
            rd_word_r <= rd_word_n;
`endif
        end
    end

endmodule
